// File: rtl/cdb_rs_if.sv
// Reservation-station bus: dispatch port, CDB snoop lanes, flush and issue handshake.
interface cdb_rs_if #(
   parameter int ROB_DEPTH = 8,
   parameter int CDB_SIZE  = 4,
   parameter int OP_W      = 10
);
   localparam int TW = $clog2(ROB_DEPTH);

   logic                               flush;
   logic                               dispatch_valid;
   logic                               dispatch_ready;
   logic [TW-1:0]                      dispatch_rob_tag;
   logic [OP_W-1:0]                    dispatch_op;
   logic                               dispatch_rs1_ready;
   logic                               dispatch_rs2_ready;
   logic [TW-1:0]                      dispatch_rs1_tag;
   logic [TW-1:0]                      dispatch_rs2_tag;
   logic [31:0]                        dispatch_rs1_data;
   logic [31:0]                        dispatch_rs2_data;
   logic [CDB_SIZE-1:0]                valid_CDB;
   logic [CDB_SIZE-1:0][TW-1:0]        tag_CDB;
   logic [CDB_SIZE-1:0][31:0]          data_CDB;
   logic                               issue_valid;
   logic                               issue_ready;
   logic [TW-1:0]                      issue_rob_tag;
   logic [OP_W-1:0]                    issue_op;
   logic [31:0]                        issue_rs1_data;
   logic [31:0]                        issue_rs2_data;

   modport master (
      output flush, dispatch_valid, dispatch_rob_tag, dispatch_op,
             dispatch_rs1_ready, dispatch_rs2_ready, dispatch_rs1_tag, dispatch_rs2_tag,
             dispatch_rs1_data, dispatch_rs2_data, valid_CDB, tag_CDB, data_CDB, issue_ready,
      input  dispatch_ready, issue_valid, issue_rob_tag, issue_op, issue_rs1_data, issue_rs2_data
   );

   modport slave (
      input  flush, dispatch_valid, dispatch_rob_tag, dispatch_op,
             dispatch_rs1_ready, dispatch_rs2_ready, dispatch_rs1_tag, dispatch_rs2_tag,
             dispatch_rs1_data, dispatch_rs2_data, valid_CDB, tag_CDB, data_CDB, issue_ready,
      output dispatch_ready, issue_valid, issue_rob_tag, issue_op, issue_rs1_data, issue_rs2_data
   );
endinterface

// File: rtl/cdb_rs.sv
// Reservation station: holds dispatched ops, snoops CDB lanes for missing
// operands, issues the oldest fully-ready entry. Age kept in an age matrix so
// ordering is independent of entry index.
module cdb_rs #(
   parameter int RS_DEPTH  = 4,
   parameter int ROB_DEPTH = 8,
   parameter int CDB_SIZE  = 4,
   parameter int OP_W      = 10
) (
   input  logic     clk,
   input  logic     rst,
   cdb_rs_if.slave  bus
);
   localparam int TW = $clog2(ROB_DEPTH);
   localparam int IW = $clog2(RS_DEPTH);

   // Entry state; only valid is reset, the rest is qualified by valid.
   logic [RS_DEPTH-1:0]                valid;
   logic [RS_DEPTH-1:0][RS_DEPTH-1:0]  older;     // older[i][j]: entry i dispatched before j
   logic [TW-1:0]                      rob_tag  [RS_DEPTH];
   logic [OP_W-1:0]                    op       [RS_DEPTH];
   logic [RS_DEPTH-1:0]                rs1_rdy;
   logic [RS_DEPTH-1:0]                rs2_rdy;
   logic [TW-1:0]                      rs1_tag  [RS_DEPTH];
   logic [TW-1:0]                      rs2_tag  [RS_DEPTH];
   logic [31:0]                        rs1_data [RS_DEPTH];
   logic [31:0]                        rs2_data [RS_DEPTH];

   logic [32:0]                        snp1 [RS_DEPTH];
   logic [32:0]                        snp2 [RS_DEPTH];
   logic [32:0]                        disp1;
   logic [32:0]                        disp2;
   logic [IW-1:0]                      free_idx;
   logic                               any_free;
   logic [RS_DEPTH-1:0]                cand;
   logic [IW-1:0]                      sel_idx;
   logic                               have_cand;
   logic                               dispatch_fire;
   logic                               issue_fire;

   // CDB lookup for one tag: {hit, data}; the lowest matching lane wins.
   function automatic logic [32:0] snoop(
      input logic [TW-1:0]               tag,
      input logic [CDB_SIZE-1:0]         v,
      input logic [CDB_SIZE-1:0][TW-1:0] t,
      input logic [CDB_SIZE-1:0][31:0]   d
   );
      logic [32:0] r;
      r = '0;
      for (int k = CDB_SIZE - 1; k >= 0; k--) begin
         if (v[k] && (t[k] == tag)) r = {1'b1, d[k]};
      end
      return r;
   endfunction

   // Snoop results for every stored source and for the incoming dispatch.
   always_comb begin
      for (int i = 0; i < RS_DEPTH; i++) begin
         snp1[i] = snoop(rs1_tag[i], bus.valid_CDB, bus.tag_CDB, bus.data_CDB);
         snp2[i] = snoop(rs2_tag[i], bus.valid_CDB, bus.tag_CDB, bus.data_CDB);
      end
      disp1 = snoop(bus.dispatch_rs1_tag, bus.valid_CDB, bus.tag_CDB, bus.data_CDB);
      disp2 = snoop(bus.dispatch_rs2_tag, bus.valid_CDB, bus.tag_CDB, bus.data_CDB);
   end

   // Lowest-index free entry for allocation.
   always_comb begin
      free_idx = '0;
      for (int i = RS_DEPTH - 1; i >= 0; i--) begin
         if (!valid[i]) free_idx = IW'(i);
      end
   end

   // Oldest ready entry: a candidate older than every other candidate.
   always_comb begin
      logic win;
      win       = 1'b0;
      sel_idx   = '0;
      have_cand = 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         win = cand[i];
         for (int j = 0; j < RS_DEPTH; j++) begin
            if ((j != i) && cand[j] && !older[i][j]) win = 1'b0;
         end
         if (win) begin
            have_cand = 1'b1;
            sel_idx   = IW'(i);
         end
      end
   end

   assign cand               = valid & rs1_rdy & rs2_rdy;
   assign any_free           = ~&valid;
   assign bus.dispatch_ready = rst | any_free;
   assign dispatch_fire      = bus.dispatch_valid && any_free && !bus.flush && !rst;
   assign bus.issue_valid    = have_cand && !bus.flush && !rst;
   assign issue_fire         = bus.issue_valid && bus.issue_ready;

   // Issue outputs come straight from the selected entry, zero when idle.
   always_comb begin
      bus.issue_rob_tag  = '0;
      bus.issue_op       = '0;
      bus.issue_rs1_data = '0;
      bus.issue_rs2_data = '0;
      if (bus.issue_valid) begin
         bus.issue_rob_tag  = rob_tag[sel_idx];
         bus.issue_op       = op[sel_idx];
         bus.issue_rs1_data = rs1_data[sel_idx];
         bus.issue_rs2_data = rs2_data[sel_idx];
      end
   end

   // Entry occupancy: reset/flush clear all, issue frees, dispatch allocates.
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         valid <= '0;
      end else begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            if (issue_fire && (sel_idx == IW'(i)))           valid[i] <= 1'b0;
            else if (dispatch_fire && (free_idx == IW'(i)))  valid[i] <= 1'b1;
         end
      end
   end

   // Payload capture on dispatch (with CDB bypass) and operand snooping.
   always_ff @(posedge clk) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (dispatch_fire && (free_idx == IW'(i))) begin
            rob_tag[i] <= bus.dispatch_rob_tag;
            op[i]      <= bus.dispatch_op;
            rs1_tag[i] <= bus.dispatch_rs1_tag;
            rs2_tag[i] <= bus.dispatch_rs2_tag;
            rs1_rdy[i] <= bus.dispatch_rs1_ready | disp1[32];
            rs2_rdy[i] <= bus.dispatch_rs2_ready | disp2[32];
            rs1_data[i] <= bus.dispatch_rs1_ready ? bus.dispatch_rs1_data : disp1[31:0];
            rs2_data[i] <= bus.dispatch_rs2_ready ? bus.dispatch_rs2_data : disp2[31:0];
         end else begin
            if (!rs1_rdy[i] && snp1[i][32]) begin
               rs1_rdy[i]  <= 1'b1;
               rs1_data[i] <= snp1[i][31:0];
            end
            if (!rs2_rdy[i] && snp2[i][32]) begin
               rs2_rdy[i]  <= 1'b1;
               rs2_data[i] <= snp2[i][31:0];
            end
         end
      end
   end

   // Age matrix: a new entry is younger than everything currently held.
   always_ff @(posedge clk) begin
      if (dispatch_fire) begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            for (int j = 0; j < RS_DEPTH; j++) begin
               if (free_idx == IW'(i))      older[i][j] <= 1'b0;
               else if (free_idx == IW'(j)) older[i][j] <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_cdb_rs.sv
// Bench for cdb_rs: directed scenarios plus random traffic, all outputs
// compared every cycle against a sequence-number based reference model.
module tb_cdb_rs;
   localparam int D  = 4;
   localparam int NL = 4;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   cdb_rs_if #(.ROB_DEPTH(8), .CDB_SIZE(NL), .OP_W(10)) bus ();

   cdb_rs #(.RS_DEPTH(D), .ROB_DEPTH(8), .CDB_SIZE(NL), .OP_W(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: unordered slots, age by global dispatch sequence number.
   bit          m_v  [D];
   int unsigned m_seq[D];
   logic [2:0]  m_tag[D];
   logic [9:0]  m_op [D];
   bit          m_r1 [D];
   bit          m_r2 [D];
   logic [2:0]  m_t1 [D];
   logic [2:0]  m_t2 [D];
   logic [31:0] m_d1 [D];
   logic [31:0] m_d2 [D];
   int unsigned seq_ctr;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle();
      bus.flush              = 1'b0;
      bus.dispatch_valid     = 1'b0;
      bus.dispatch_rob_tag   = '0;
      bus.dispatch_op        = '0;
      bus.dispatch_rs1_ready = 1'b0;
      bus.dispatch_rs2_ready = 1'b0;
      bus.dispatch_rs1_tag   = '0;
      bus.dispatch_rs2_tag   = '0;
      bus.dispatch_rs1_data  = '0;
      bus.dispatch_rs2_data  = '0;
      bus.valid_CDB          = '0;
      bus.tag_CDB            = '0;
      bus.data_CDB           = '0;
      bus.issue_ready        = 1'b0;
   endtask

   task automatic disp(input logic [2:0] tag, input logic [9:0] opv,
                       input bit r1, input logic [2:0] t1, input logic [31:0] d1,
                       input bit r2, input logic [2:0] t2, input logic [31:0] d2);
      bus.dispatch_valid     = 1'b1;
      bus.dispatch_rob_tag   = tag;
      bus.dispatch_op        = opv;
      bus.dispatch_rs1_ready = r1;
      bus.dispatch_rs1_tag   = t1;
      bus.dispatch_rs1_data  = d1;
      bus.dispatch_rs2_ready = r2;
      bus.dispatch_rs2_tag   = t2;
      bus.dispatch_rs2_data  = d2;
   endtask

   task automatic lane(input int k, input logic [2:0] tag, input logic [31:0] data);
      bus.valid_CDB[k] = 1'b1;
      bus.tag_CDB[k]   = tag;
      bus.data_CDB[k]  = data;
   endtask

   // First lane (lowest index) carrying the tag, if any.
   task automatic cdb_find(input logic [2:0] tag, output bit hit, output logic [31:0] data);
      hit  = 1'b0;
      data = '0;
      for (int k = 0; k < NL; k++) begin
         if (bus.valid_CDB[k] && bus.tag_CDB[k] == tag) begin
            hit  = 1'b1;
            data = bus.data_CDB[k];
            break;
         end
      end
   endtask

   // One cycle: compare outputs with the model, then advance the model at the edge.
   task automatic tick();
      int          sel;
      int          cnt;
      bit          ev;
      bit          hit;
      logic [31:0] hd;
      #2;
      sel = -1;
      cnt = 0;
      for (int i = 0; i < D; i++) begin
         if (m_v[i]) cnt++;
         if (m_v[i] && m_r1[i] && m_r2[i] && (sel < 0 || m_seq[i] < m_seq[sel])) sel = i;
      end
      ev = (sel >= 0) && !bus.flush && !rst;
      chk_val("dispatch_ready", 32'(bus.dispatch_ready), (rst || cnt < D) ? 32'd1 : 32'd0);
      chk_val("issue_valid", 32'(bus.issue_valid), 32'(ev));
      chk_val("issue_rob_tag", 32'(bus.issue_rob_tag), ev ? 32'(m_tag[sel]) : 32'd0);
      chk_val("issue_op", 32'(bus.issue_op), ev ? 32'(m_op[sel]) : 32'd0);
      chk_val("issue_rs1_data", bus.issue_rs1_data, ev ? m_d1[sel] : 32'd0);
      chk_val("issue_rs2_data", bus.issue_rs2_data, ev ? m_d2[sel] : 32'd0);
      @(posedge clk);
      if (rst || bus.flush) begin
         for (int i = 0; i < D; i++) m_v[i] = 1'b0;
      end else begin
         if (ev && bus.issue_ready) m_v[sel] = 1'b0;
         for (int i = 0; i < D; i++) begin
            if (m_v[i] && !m_r1[i]) begin
               cdb_find(m_t1[i], hit, hd);
               if (hit) begin m_r1[i] = 1'b1; m_d1[i] = hd; end
            end
            if (m_v[i] && !m_r2[i]) begin
               cdb_find(m_t2[i], hit, hd);
               if (hit) begin m_r2[i] = 1'b1; m_d2[i] = hd; end
            end
         end
         if (bus.dispatch_valid && cnt < D) begin
            for (int i = 0; i < D; i++) begin
               if (!m_v[i]) begin
                  m_v[i]   = 1'b1;
                  m_seq[i] = seq_ctr++;
                  m_tag[i] = bus.dispatch_rob_tag;
                  m_op[i]  = bus.dispatch_op;
                  m_t1[i]  = bus.dispatch_rs1_tag;
                  m_t2[i]  = bus.dispatch_rs2_tag;
                  m_r1[i]  = bus.dispatch_rs1_ready;
                  m_d1[i]  = bus.dispatch_rs1_data;
                  m_r2[i]  = bus.dispatch_rs2_ready;
                  m_d2[i]  = bus.dispatch_rs2_data;
                  if (!m_r1[i]) begin
                     cdb_find(m_t1[i], hit, hd);
                     if (hit) begin m_r1[i] = 1'b1; m_d1[i] = hd; end
                  end
                  if (!m_r2[i]) begin
                     cdb_find(m_t2[i], hit, hd);
                     if (hit) begin m_r2[i] = 1'b1; m_d2[i] = hd; end
                  end
                  break;
               end
            end
         end
      end
      #1;
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      seq_ctr = 0;
      for (int i = 0; i < D; i++) m_v[i] = 1'b0;
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) tick();

      // Both sources ready: issues the next cycle, gone the cycle after.
      disp(3'd3, 10'h011, 1'b1, 3'd0, 32'd5, 1'b1, 3'd0, 32'd7);
      bus.issue_ready = 1'b1;
      tick();
      idle(); bus.issue_ready = 1'b1; #1;
      chk_val("s1_valid", 32'(bus.issue_valid), 32'd1);
      chk_val("s1_tag", 32'(bus.issue_rob_tag), 32'd3);
      chk_val("s1_rs1", bus.issue_rs1_data, 32'd5);
      chk_val("s1_rs2", bus.issue_rs2_data, 32'd7);
      tick();
      idle(); bus.issue_ready = 1'b1; #1;
      chk_val("s1_gone", 32'(bus.issue_valid), 32'd0);
      tick();

      // rs1 waits on tag 2, delivered on lane 1 two cycles later.
      disp(3'd1, 10'h022, 1'b0, 3'd2, 32'd0, 1'b1, 3'd0, 32'd9);
      bus.issue_ready = 1'b1;
      tick();
      idle(); bus.issue_ready = 1'b1;
      tick();
      idle(); bus.issue_ready = 1'b1; lane(1, 3'd2, 32'hDEADBEEF); #1;
      chk_val("s2_wait", 32'(bus.issue_valid), 32'd0);
      tick();
      idle(); bus.issue_ready = 1'b1; #1;
      chk_val("s2_valid", 32'(bus.issue_valid), 32'd1);
      chk_val("s2_rs1", bus.issue_rs1_data, 32'hDEADBEEF);
      tick();
      idle(); tick();

      // Dispatch bypass: rs2 tag 5 on lane 3 in the dispatch cycle.
      disp(3'd6, 10'h033, 1'b1, 3'd0, 32'h44, 1'b0, 3'd5, 32'd0);
      lane(3, 3'd5, 32'h10);
      bus.issue_ready = 1'b1;
      tick();
      idle(); bus.issue_ready = 1'b1; #1;
      chk_val("s3_valid", 32'(bus.issue_valid), 32'd1);
      chk_val("s3_rs2", bus.issue_rs2_data, 32'h10);
      tick();
      idle(); tick();

      // Fill, ignored fifth dispatch, older waiting entry wins once ready.
      disp(3'd4, 10'h0A0, 1'b0, 3'd6, 32'd0, 1'b1, 3'd0, 32'd1); tick();
      disp(3'd5, 10'h0B0, 1'b1, 3'd0, 32'd2, 1'b1, 3'd0, 32'd3); tick();
      disp(3'd6, 10'h0C0, 1'b1, 3'd0, 32'd4, 1'b1, 3'd0, 32'd5); tick();
      disp(3'd7, 10'h0D0, 1'b1, 3'd0, 32'd6, 1'b1, 3'd0, 32'd7); tick();
      disp(3'd0, 10'h0E0, 1'b1, 3'd0, 32'd8, 1'b1, 3'd0, 32'd9); #1;
      chk_val("s4_full", 32'(bus.dispatch_ready), 32'd0);
      chk_val("s4_b_first", 32'(bus.issue_rob_tag), 32'd5);
      tick();
      idle(); lane(0, 3'd6, 32'hAA); tick();
      idle(); #1;
      chk_val("s4_a_oldest", 32'(bus.issue_rob_tag), 32'd4);
      chk_val("s4_a_rs1", bus.issue_rs1_data, 32'hAA);
      bus.issue_ready = 1'b1;
      tick();
      idle(); #1;
      chk_val("s4_freed", 32'(bus.dispatch_ready), 32'd1);
      chk_val("s4_next", 32'(bus.issue_rob_tag), 32'd5);
      for (int c = 0; c < 4; c++) begin
         idle(); bus.issue_ready = 1'b1; tick();
      end

      // Flush with a ready entry and a concurrent dispatch.
      idle(); disp(3'd2, 10'h101, 1'b0, 3'd3, 32'd0, 1'b1, 3'd0, 32'd1); tick();
      idle(); disp(3'd3, 10'h102, 1'b1, 3'd0, 32'd2, 1'b1, 3'd0, 32'd3); tick();
      idle(); disp(3'd1, 10'h103, 1'b1, 3'd0, 32'd4, 1'b1, 3'd0, 32'd5);
      bus.flush = 1'b1; bus.issue_ready = 1'b1; #1;
      chk_val("s5_no_issue", 32'(bus.issue_valid), 32'd0);
      tick();
      idle(); bus.issue_ready = 1'b1; #1;
      chk_val("s5_empty", 32'(bus.issue_valid), 32'd0);
      tick();
      idle(); bus.issue_ready = 1'b1; lane(0, 3'd3, 32'h77); tick();
      for (int c = 0; c < 3; c++) begin
         idle(); bus.issue_ready = 1'b1; tick();
      end

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         idle();
         rst = ($urandom_range(0, 199) == 0);
         bus.flush = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 1) == 1) begin
            disp(3'($urandom_range(0, 7)), 10'($urandom),
                 1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), $urandom);
         end
         for (int k = 0; k < NL; k++) begin
            if ($urandom_range(0, 4) < 2) lane(k, 3'($urandom_range(0, 7)), $urandom);
         end
         bus.issue_ready = ($urandom_range(0, 4) < 3);
         tick();
      end
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
